// File: rtl/csa_pkg.sv
// Shared constants and sizing helper for the carry-select adder.
package csa_pkg;

   localparam int DEFAULT_WIDTH   = 2;
   localparam int DEFAULT_BLOCK_W = 1;

   // Number of carry-select blocks; the last block absorbs any remainder bits.
   function automatic int num_blocks(input int width, input int block_w);
      return (width + block_w - 1) / block_w;
   endfunction

endpackage

// File: rtl/rca_block.sv
// Parameterised ripple-carry adder built from full-adder equations.
module rca_block #(
   parameter int W = 1
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         cin,
   output logic [W-1:0] s,
   output logic         cout
);

   logic [W:0] w_c;

   assign w_c[0] = cin;

   for (genvar i = 0; i < W; i++) begin : g_fa
      assign s[i]     = a[i] ^ b[i] ^ w_c[i];
      assign w_c[i+1] = (a[i] & b[i]) | (w_c[i] & (a[i] ^ b[i]));
   end

   assign cout = w_c[W];

endmodule

// File: rtl/csa_adder.sv
// Carry-select adder with registered {Cout,Sum} = A + B and one cycle of latency.
module csa_adder
   import csa_pkg::*;
#(
   parameter int WIDTH   = DEFAULT_WIDTH,
   parameter int BLOCK_W = DEFAULT_BLOCK_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic [WIDTH-1:0] Sum,
   output logic             Cout
);

   localparam int NB = num_blocks(WIDTH, BLOCK_W);

   logic [NB:0]      w_carry;
   logic [WIDTH-1:0] w_sum;
   logic [WIDTH-1:0] r_sum;
   logic             r_cout;

   assign w_carry[0] = 1'b0;

   for (genvar g = 0; g < NB; g++) begin : g_blk
      localparam int LO = g * BLOCK_W;
      localparam int BW = ((LO + BLOCK_W) > WIDTH) ? (WIDTH - LO) : BLOCK_W;

      if (g == 0) begin : g_first
         rca_block #(.W(BW)) u_rca (
            .a    (A[LO +: BW]),
            .b    (B[LO +: BW]),
            .cin  (1'b0),
            .s    (w_sum[LO +: BW]),
            .cout (w_carry[g+1])
         );
      end else begin : g_sel
         logic [BW-1:0] w_s0;
         logic [BW-1:0] w_s1;
         logic          w_c0;
         logic          w_c1;

         rca_block #(.W(BW)) u_rca0 (
            .a    (A[LO +: BW]),
            .b    (B[LO +: BW]),
            .cin  (1'b0),
            .s    (w_s0),
            .cout (w_c0)
         );

         rca_block #(.W(BW)) u_rca1 (
            .a    (A[LO +: BW]),
            .b    (B[LO +: BW]),
            .cin  (1'b1),
            .s    (w_s1),
            .cout (w_c1)
         );

         // Previous block's carry picks the precomputed result.
         assign w_sum[LO +: BW] = w_carry[g] ? w_s1 : w_s0;
         assign w_carry[g+1]    = w_carry[g] ? w_c1 : w_c0;
      end
   end

   // Output registers; reset forces constants so X operands never leak through.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_sum  <= '0;
         r_cout <= 1'b0;
      end else begin
         r_sum  <= w_sum;
         r_cout <= w_carry[NB];
      end
   end

   assign Sum  = r_sum;
   assign Cout = r_cout;

endmodule

// File: tb/tb_csa_adder.sv
// Directed and random self-checking bench for csa_adder at 2/1 and 8/3 configurations.
module tb_csa_adder;

   logic       clk = 1'b0;
   logic       rst2;
   logic       rst8;
   logic [1:0] a2;
   logic [1:0] b2;
   logic [1:0] s2;
   logic       c2;
   logic [7:0] a8;
   logic [7:0] b8;
   logic [7:0] s8;
   logic       c8;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   csa_adder #(.WIDTH(2), .BLOCK_W(1)) u_dut2 (
      .clk  (clk),
      .rst  (rst2),
      .A    (a2),
      .B    (b2),
      .Sum  (s2),
      .Cout (c2)
   );

   csa_adder #(.WIDTH(8), .BLOCK_W(3)) u_dut8 (
      .clk  (clk),
      .rst  (rst8),
      .A    (a8),
      .B    (b8),
      .Sum  (s8),
      .Cout (c8)
   );

   task automatic step(input logic [1:0] a, input logic [1:0] b, input logic r2,
                       input logic [7:0] x, input logic [7:0] y, input logic r8);
      a2   = a;
      b2   = b;
      rst2 = r2;
      a8   = x;
      b8   = y;
      rst8 = r8;
      @(posedge clk);
      #1;
   endtask

   task automatic chk2(input string tag, input logic [2:0] exp);
      n_checks++;
      assert ({c2, s2} === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%b expected=%b", tag, {c2, s2}, exp);
      end
   endtask

   task automatic chk8(input string tag, input logic [8:0] exp);
      n_checks++;
      assert ({c8, s8} === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, {c8, s8}, exp);
      end
   endtask

   initial begin
      logic [1:0] ea;
      logic [1:0] eb;
      logic [7:0] ra;
      logic [7:0] rb;

      // Reset for two cycles with unknown operands.
      step(2'bxx, 2'bxx, 1'b1, 8'hxx, 8'hxx, 1'b1);
      chk2("rst2_c1", 3'b000);
      chk8("rst8_c1", 9'd0);
      step(2'b11, 2'b11, 1'b1, 8'hFF, 8'hFF, 1'b1);
      chk2("rst2_c2", 3'b000);
      chk8("rst8_c2", 9'd0);

      step(2'b10, 2'b01, 1'b0, 8'd0, 8'd0, 1'b1);
      chk2("a10_b01", 3'b011);
      step(2'b01, 2'b10, 1'b0, 8'd0, 8'd0, 1'b1);
      chk2("a01_b10", 3'b011);
      step(2'b11, 2'b01, 1'b0, 8'd0, 8'd0, 1'b1);
      chk2("a11_b01", 3'b100);
      step(2'b01, 2'b11, 1'b0, 8'd0, 8'd0, 1'b1);
      chk2("a01_b11", 3'b100);
      step(2'b00, 2'b01, 1'b0, 8'd0, 8'd0, 1'b1);
      chk2("a00_b01", 3'b001);
      step(2'b01, 2'b01, 1'b0, 8'd0, 8'd0, 1'b1);
      chk2("a01_b01", 3'b010);
      step(2'b00, 2'b00, 1'b0, 8'd0, 8'd0, 1'b1);
      chk2("a00_b00", 3'b000);
      step(2'b11, 2'b11, 1'b0, 8'd0, 8'd0, 1'b1);
      chk2("a11_b11", 3'b110);

      // Exhaustive back-to-back sweep with a reset pulse (nonzero operands) mid-stream.
      for (int i = 0; i < 16; i++) begin
         ea = 2'(i >> 2);
         eb = 2'(i & 3);
         if (i == 8) begin
            step(2'b11, 2'b10, 1'b1, 8'd0, 8'd0, 1'b1);
            chk2("exh_midrst", 3'b000);
         end
         step(ea, eb, 1'b0, 8'd0, 8'd0, 1'b1);
         chk2($sformatf("exh_%0d_%0d", ea, eb), {1'b0, ea} + {1'b0, eb});
      end

      step(2'b00, 2'b00, 1'b1, 8'd255, 8'd1, 1'b0);
      chk8("w8_255p1", 9'h100);
      step(2'b00, 2'b00, 1'b1, 8'd200, 8'd100, 1'b0);
      chk8("w8_200p100", {1'b1, 8'd44});
      step(2'b00, 2'b00, 1'b1, 8'd255, 8'd255, 1'b0);
      chk8("w8_255p255", 9'd510);
      step(2'b00, 2'b00, 1'b1, 8'd7, 8'd1, 1'b0);
      chk8("w8_7p1", 9'd8);
      step(2'b00, 2'b00, 1'b1, 8'd63, 8'd1, 1'b0);
      chk8("w8_63p1", 9'd64);
      step(2'b00, 2'b00, 1'b1, 8'd200, 8'd100, 1'b1);
      chk8("w8_midrst", 9'd0);
      step(2'b00, 2'b00, 1'b1, 8'd18, 8'd5, 1'b0);
      chk8("w8_after_rst", 9'd23);

      for (int k = 0; k < 1000; k++) begin
         ra = 8'($urandom_range(255, 0));
         rb = 8'($urandom_range(255, 0));
         step(2'b00, 2'b00, 1'b1, ra, rb, 1'b0);
         chk8($sformatf("rnd_%0d", k), {1'b0, ra} + {1'b0, rb});
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
